// File: rtl/sprite_ram_loader_if.sv
// sprite_ram_loader_if: packed pixel byte stream in, sprite RAM write port out
interface sprite_ram_loader_if #(
  parameter int ADDRW     = 16,
  parameter int COLR_BITS = 4
);
  logic                 i_valid;
  logic [7:0]           i_data;
  logic                 o_ready;
  logic                 wr_en;
  logic [ADDRW-1:0]     wr_addr;
  logic [COLR_BITS-1:0] wr_data;
  modport master (output i_valid, i_data, input o_ready, wr_en, wr_addr, wr_data);
  modport slave  (input i_valid, i_data, output o_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: vblank-gated byte-to-pixel writer into sprite RAM; SPRITE_LOAD_CHECKSUM_EN adds o_checksum
module sprite_ram_loader #(
  parameter int WIDTH     = 512,
  parameter int HEIGHT    = 128,
  parameter int FRAMES    = 1,
  parameter int COLR_BITS = 4,
  parameter int PIXELS    = WIDTH * HEIGHT,
  parameter int DEPTH     = PIXELS * FRAMES,
  parameter int ADDRW     = $clog2(DEPTH),
  parameter int FRAMEW    = FRAMES > 1 ? $clog2(FRAMES) : 1
) (
  input  logic              i_clk_25,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [FRAMEW-1:0] i_frame,
  input  logic              i_abort,
  input  logic              i_vblank,
  sprite_ram_loader_if.slave bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
`ifdef SPRITE_LOAD_CHECKSUM_EN
  ,
  output logic [7:0]        o_checksum
`endif
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state, state_n;
  logic [ADDRW-1:0] base, count;
  logic [COLR_BITS-1:0] hold;
  logic bad_frame, start_ok, fire, last_lo, last_hi;
  assign bad_frame = 32'(i_frame) >= FRAMES;
  assign start_ok  = state == IDLE && i_start && !i_abort && !bad_frame;
  assign bus.o_ready = state == LO && i_vblank;
  assign fire      = bus.o_ready && bus.i_valid;
  assign last_lo   = 32'(count) + 32'd1 == PIXELS;
  assign last_hi   = 32'(count) + 32'd2 == PIXELS;
  assign o_busy    = state == LO || state == HI;
  // state register
  always_ff @(posedge i_clk_25 or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  // next state: abort always returns to IDLE; HI completes regardless of vblank
  always_comb begin
    state_n = i_abort ? IDLE :
              state == IDLE ? (start_ok ? LO : IDLE) :
              state == LO   ? (fire ? (last_lo ? DONE : HI) : LO) :
              state == HI   ? (last_hi ? DONE : LO) : IDLE;
  end
  // registered write port, frame base/pixel counter and status pulses
  always_ff @(posedge i_clk_25 or negedge i_rst_n)
    if (!i_rst_n) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      base        <= '0;
      count       <= '0;
      hold        <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      o_done    <= state == DONE && !i_abort;
      o_err     <= state == IDLE && i_start && !i_abort && bad_frame;
      if (start_ok) begin
        base  <= ADDRW'(i_frame) * ADDRW'(PIXELS);
        count <= '0;
      end
      if (fire && !i_abort) begin
        bus.wr_en   <= 1'b1;
        bus.wr_addr <= base + count;
        bus.wr_data <= bus.i_data[3:0];
        hold        <= bus.i_data[7:4];
      end
      if (state == HI && !i_abort) begin
        bus.wr_en   <= 1'b1;
        bus.wr_addr <= base + count + ADDRW'(1);
        bus.wr_data <= hold;
        count       <= count + ADDRW'(2);
      end
    end
`ifdef SPRITE_LOAD_CHECKSUM_EN
  // running byte sum, cleared by an accepted start, frozen by abort
  always_ff @(posedge i_clk_25 or negedge i_rst_n)
    if (!i_rst_n) o_checksum <= '0;
    else if (start_ok) o_checksum <= '0;
    else if (fire && !i_abort) o_checksum <= o_checksum + bus.i_data;
`endif
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader: directed vector bench for sprite_ram_loader
module tb_sprite_ram_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  logic a_start = 0, a_abort = 0, a_vblank = 0, a_busy, a_done, a_err;
  logic [1:0] a_frame = '0;
  sprite_ram_loader_if #(.ADDRW(5), .COLR_BITS(4)) bus_a ();
`ifdef SPRITE_LOAD_CHECKSUM_EN
  logic [7:0] a_sum;
`endif
  sprite_ram_loader #(.WIDTH(4), .HEIGHT(2), .FRAMES(3)) dut_a (
    .i_clk_25(clk), .i_rst_n(rst_n), .i_start(a_start), .i_frame(a_frame),
    .i_abort(a_abort), .i_vblank(a_vblank), .bus(bus_a),
    .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
`ifdef SPRITE_LOAD_CHECKSUM_EN
    , .o_checksum(a_sum)
`endif
  );

  logic b_start = 0, b_abort = 0, b_vblank = 0, b_busy, b_done, b_err;
  logic [0:0] b_frame = '0;
  sprite_ram_loader_if #(.ADDRW(2), .COLR_BITS(4)) bus_b ();
`ifdef SPRITE_LOAD_CHECKSUM_EN
  logic [7:0] b_sum;
`endif
  sprite_ram_loader #(.WIDTH(3), .HEIGHT(1), .FRAMES(1)) dut_b (
    .i_clk_25(clk), .i_rst_n(rst_n), .i_start(b_start), .i_frame(b_frame),
    .i_abort(b_abort), .i_vblank(b_vblank), .bus(bus_b),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
`ifdef SPRITE_LOAD_CHECKSUM_EN
    , .o_checksum(b_sum)
`endif
  );

  typedef struct {
    logic st; logic [1:0] fr; logic ab, vb, vl; logic [7:0] d;
    logic rd, we; logic [4:0] ad; logic [3:0] wd; logic bz, dn, er;
  } vec_t;
  vec_t tv[$];
  int checks = 0, failures = 0;

  function automatic vec_t mk(logic st, logic [1:0] fr, logic ab, logic vb, logic vl, logic [7:0] d,
                              logic rd, logic we, logic [4:0] ad, logic [3:0] wd, logic bz, logic dn, logic er);
    vec_t v;
    v.st = st; v.fr = fr; v.ab = ab; v.vb = vb; v.vl = vl; v.d = d;
    v.rd = rd; v.we = we; v.ad = ad; v.wd = wd; v.bz = bz; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic b_drive(input logic st, input logic vl, input logic [7:0] d);
    @(negedge clk);
    b_start = st; b_vblank = 1'b1; bus_b.i_valid = vl; bus_b.i_data = d;
    #1;
  endtask

  function automatic logic [15:0] b_snap();
    return {7'd0, bus_b.o_ready, bus_b.wr_en, bus_b.wr_en ? bus_b.wr_addr : 2'd0,
            bus_b.wr_en ? bus_b.wr_data : 4'd0, b_busy, b_done};
  endfunction

  initial begin
    logic [14:0] exp_v, act_v;
    bus_a.i_valid = 0; bus_a.i_data = '0;
    bus_b.i_valid = 0; bus_b.i_data = '0;
    // frame 1 (base 8), four bytes back to back
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(1,1,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h21, 1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h43, 0,1, 8,1,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h43, 1,1, 9,2,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h65, 0,1,10,3,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h65, 1,1,11,4,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h87, 0,1,12,5,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h87, 1,1,13,6,1,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,1,14,7,1,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,1,15,8,0,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,1,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    // same load with vblank low for 5 cycles after the first byte
    tv.push_back(mk(1,1,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h21, 1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,1,8'h43, 0,1, 8,1,1,0,0));
    tv.push_back(mk(0,0,0,0,1,8'h43, 0,1, 9,2,1,0,0));
    tv.push_back(mk(0,0,0,0,1,8'h43, 0,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,1,8'h43, 0,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,1,8'h43, 0,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h43, 1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h65, 0,1,10,3,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h65, 1,1,11,4,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h87, 0,1,12,5,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h87, 1,1,13,6,1,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,1,14,7,1,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,1,15,8,0,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,1,0));
    // out-of-range frame
    tv.push_back(mk(1,3,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h21, 0,0, 0,0,0,0,1));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    // abort on the second accepted byte, restart, abort during HI, abort+start in IDLE
    tv.push_back(mk(1,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h21, 1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h43, 0,1, 0,1,1,0,0));
    tv.push_back(mk(0,0,1,1,1,8'h43, 1,1, 1,2,1,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(1,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,0,1,1,8'h21, 1,0, 0,0,1,0,0));
    tv.push_back(mk(0,0,1,1,0,8'h00, 0,1, 0,1,1,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(1,0,1,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0,8'h00, 0,0, 0,0,0,0,0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (tv[i]) begin
      @(negedge clk);
      a_start = tv[i].st; a_frame = tv[i].fr; a_abort = tv[i].ab; a_vblank = tv[i].vb;
      bus_a.i_valid = tv[i].vl; bus_a.i_data = tv[i].d;
      #1;
      exp_v = {tv[i].rd, tv[i].we, tv[i].we ? tv[i].ad : 5'd0, tv[i].we ? tv[i].wd : 4'd0,
               tv[i].bz, tv[i].dn, tv[i].er};
      act_v = {bus_a.o_ready, bus_a.wr_en, tv[i].we ? bus_a.wr_addr : 5'd0,
               tv[i].we ? bus_a.wr_data : 4'd0, a_busy, a_done, a_err};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL vec%0d {rdy,we,addr,data,busy,done,err}: got %b want %b", i, act_v, exp_v);
      end
`ifdef SPRITE_LOAD_CHECKSUM_EN
      if (i == 11) chk("checksum", {8'd0, a_sum}, 16'h0050);
`endif
    end
    a_start = 0; a_abort = 0; bus_a.i_valid = 0;

    // 3-pixel sprite: odd pixel count ends in LO, high nibble of last byte discarded
    b_drive(1, 0, 8'h00); chk("b_idle",  b_snap(), 16'h0000);
    b_drive(0, 1, 8'h21); chk("b_lo0",   b_snap(), {7'd0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0});
    b_drive(0, 1, 8'h53); chk("b_wr0",   b_snap(), {7'd0, 1'b0, 1'b1, 2'd0, 4'd1, 1'b1, 1'b0});
    b_drive(0, 1, 8'h53); chk("b_wr1",   b_snap(), {7'd0, 1'b1, 1'b1, 2'd1, 4'd2, 1'b1, 1'b0});
    b_drive(0, 0, 8'h00); chk("b_wr2",   b_snap(), {7'd0, 1'b0, 1'b1, 2'd2, 4'd3, 1'b0, 1'b0});
    b_drive(0, 0, 8'h00); chk("b_done",  b_snap(), {7'd0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1});
    b_drive(0, 0, 8'h00); chk("b_after", b_snap(), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
